// File: rtl/ball_render_pkg.sv
// Shared constants, FSM encoding and colour codes for the bouncing-ball pixel stage.
package ball_render_pkg;

    localparam int HRES     = 640;
    localparam int VRES     = 480;
    localparam int RADIUS   = 100;
    localparam int X0_DFLT  = 320;
    localparam int Y0_DFLT  = 240;
    localparam int PIPE_LAT = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP_X = 2'd1,
        STEP_Y = 2'd2,
        COMMIT = 2'd3
    } motion_state_t;

    typedef struct packed {
        logic red;
        logic grn;
        logic blu;
    } rgb_t;

    localparam rgb_t RGB_BLACK = 3'b000;
    localparam rgb_t RGB_RED   = 3'b100;
    localparam rgb_t RGB_WHITE = 3'b111;

    // Speed select maps to 0/1/2/4 pixels per frame per axis.
    function automatic logic [2:0] step_size(input logic [1:0] sel);
        case (sel)
            2'd0:    return 3'd0;
            2'd1:    return 3'd1;
            2'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ball_render_motion.sv
// Per-frame ball motion: steps the working centre on each vblank rising edge, bouncing
// off the visible-area edges, and publishes it to the committed centre only inside vblank.
module ball_render_motion
    import ball_render_pkg::*;
#(
    parameter int HRES   = ball_render_pkg::HRES,
    parameter int VRES   = ball_render_pkg::VRES,
    parameter int RADIUS = ball_render_pkg::RADIUS,
    parameter int X0     = X0_DFLT,
    parameter int Y0     = Y0_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblank,
    input  logic [1:0]  sel,
    output logic [11:0] cx_c,
    output logic [11:0] cy_c,
    output logic        frame
);

    localparam logic [11:0]        LO_U  = 12'(RADIUS);
    localparam logic [11:0]        XHI_U = 12'(HRES - 1 - RADIUS);
    localparam logic [11:0]        YHI_U = 12'(VRES - 1 - RADIUS);
    localparam logic signed [13:0] LO_S  = 14'(RADIUS);
    localparam logic signed [13:0] XHI_S = 14'(HRES - 1 - RADIUS);
    localparam logic signed [13:0] YHI_S = 14'(VRES - 1 - RADIUS);

    motion_state_t     state;
    logic [11:0]       cx, cy;
    logic              dir_x, dir_y;   // 1 = moving toward smaller coordinates
    logic [2:0]        step;
    logic              vb_q;
    logic              tick;
    logic signed [13:0] nx, ny;

    assign tick = vblank & ~vb_q;
    assign nx   = dir_x ? $signed({2'b00, cx}) - $signed({11'd0, step})
                        : $signed({2'b00, cx}) + $signed({11'd0, step});
    assign ny   = dir_y ? $signed({2'b00, cy}) - $signed({11'd0, step})
                        : $signed({2'b00, cy}) + $signed({11'd0, step});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cx    <= 12'(X0);
            cy    <= 12'(Y0);
            cx_c  <= 12'(X0);
            cy_c  <= 12'(Y0);
            dir_x <= 1'b0;
            dir_y <= 1'b0;
            step  <= 3'd0;
            // Treat vblank as already high so a reset released inside blank is not a tick.
            vb_q  <= 1'b1;
            frame <= 1'b0;
        end else begin
            vb_q  <= vblank;
            frame <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        step  <= step_size(sel);
                        frame <= 1'b1;
                        state <= STEP_X;
                    end
                end
                STEP_X: begin
                    if (nx < LO_S) begin
                        cx    <= LO_U;
                        dir_x <= 1'b0;
                    end else if (nx > XHI_S) begin
                        cx    <= XHI_U;
                        dir_x <= 1'b1;
                    end else begin
                        cx    <= nx[11:0];
                    end
                    state <= STEP_Y;
                end
                STEP_Y: begin
                    if (ny < LO_S) begin
                        cy    <= LO_U;
                        dir_y <= 1'b0;
                    end else if (ny > YHI_S) begin
                        cy    <= YHI_U;
                        dir_y <= 1'b1;
                    end else begin
                        cy    <= ny[11:0];
                    end
                    state <= COMMIT;
                end
                COMMIT: begin
                    // Missed the blank window: hold until the next blank so no frame tears.
                    if (vblank) begin
                        cx_c  <= cx;
                        cy_c  <= cy;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ball_render.sv
// Pixel stage: 3-cycle colour pipeline drawing a filled circle plus red border, with syncs
// delayed to match. No backpressure: one pixel in and one out every clock.
module ball_render
    import ball_render_pkg::*;
#(
    parameter int HRES   = ball_render_pkg::HRES,
    parameter int VRES   = ball_render_pkg::VRES,
    parameter int RADIUS = ball_render_pkg::RADIUS,
    parameter int X0     = X0_DFLT,
    parameter int Y0     = Y0_DFLT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic        i_hblank,
    input  logic        i_vblank,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  logic [1:0]  i_sel,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_red,
    output logic        o_grn,
    output logic        o_blu,
    output logic        o_frame
);

    localparam logic [25:0] R_SQ = 26'(RADIUS * RADIUS);

    logic [11:0] cx_c, cy_c;

    ball_render_motion #(
        .HRES   (HRES),
        .VRES   (VRES),
        .RADIUS (RADIUS),
        .X0     (X0),
        .Y0     (Y0)
    ) u_motion (
        .clk    (i_clk),
        .rst    (i_rst),
        .vblank (i_vblank),
        .sel    (i_sel),
        .cx_c   (cx_c),
        .cy_c   (cy_c),
        .frame  (o_frame)
    );

    logic [PIPE_LAT-1:0] hs_sr, vs_sr;
    logic signed [12:0]  s1_dx, s1_dy;
    logic                s1_border, s1_blank;
    logic                s2_inside, s2_border, s2_blank;
    rgb_t                s3_rgb;

    logic signed [25:0]  dx_sq, dy_sq;
    logic [25:0]         d2;

    assign dx_sq = 26'(s1_dx) * 26'(s1_dx);
    assign dy_sq = 26'(s1_dy) * 26'(s1_dy);
    assign d2    = $unsigned(dx_sq) + $unsigned(dy_sq);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hs_sr     <= '1;
            vs_sr     <= '1;
            s1_dx     <= '0;
            s1_dy     <= '0;
            s1_border <= 1'b0;
            s1_blank  <= 1'b1;
            s2_inside <= 1'b0;
            s2_border <= 1'b0;
            s2_blank  <= 1'b1;
            s3_rgb    <= RGB_BLACK;
        end else begin
            hs_sr <= {hs_sr[PIPE_LAT-2:0], i_hsync};
            vs_sr <= {vs_sr[PIPE_LAT-2:0], i_vsync};

            s1_dx     <= $signed({1'b0, i_x}) - $signed({1'b0, cx_c});
            s1_dy     <= $signed({1'b0, i_y}) - $signed({1'b0, cy_c});
            s1_border <= (i_x == 12'd0) || (i_x == 12'(HRES - 1)) ||
                         (i_y == 12'd0) || (i_y == 12'(VRES - 1));
            s1_blank  <= i_hblank | i_vblank;

            s2_inside <= d2 < R_SQ;
            s2_border <= s1_border;
            s2_blank  <= s1_blank;

            if (s2_blank)
                s3_rgb <= RGB_BLACK;
            else if (s2_border)
                s3_rgb <= RGB_RED;
            else if (s2_inside)
                s3_rgb <= RGB_WHITE;
            else
                s3_rgb <= RGB_BLACK;
        end
    end

    assign o_hsync = hs_sr[PIPE_LAT-1];
    assign o_vsync = vs_sr[PIPE_LAT-1];
    assign o_red   = s3_rgb.red;
    assign o_grn   = s3_rgb.grn;
    assign o_blu   = s3_rgb.blu;

endmodule

// File: tb/tb_ball_render.sv
// Directed bench for ball_render: reset, pixel colours, pipeline alignment, motion/bounce,
// mid-frame commit safety and mid-line reset.
module tb_ball_render;

    logic        clk = 1'b0;
    logic        rst, hsync, vsync, hblank, vblank;
    logic [11:0] x, y;
    logic [1:0]  sel;
    logic        o_hsync, o_vsync, o_red, o_grn, o_blu, o_frame;
    logic        c_hsync, c_vsync, c_red, c_grn, c_blu, c_frame;
    logic [2:0]  rgb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rgb = {o_red, o_grn, o_blu};

    ball_render dut (
        .i_clk(clk), .i_rst(rst), .i_hsync(hsync), .i_vsync(vsync),
        .i_hblank(hblank), .i_vblank(vblank), .i_x(x), .i_y(y), .i_sel(sel),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_red(o_red), .o_grn(o_grn),
        .o_blu(o_blu), .o_frame(o_frame)
    );

    // Second instance starts near the bottom-right corner to exercise a double bounce.
    ball_render #(.X0(536), .Y0(376)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_hsync(hsync), .i_vsync(vsync),
        .i_hblank(hblank), .i_vblank(vblank), .i_x(x), .i_y(y), .i_sel(sel),
        .o_hsync(c_hsync), .o_vsync(c_vsync), .o_red(c_red), .o_grn(c_grn),
        .o_blu(c_blu), .o_frame(c_frame)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick(output int pulses);
        pulses = 0;
        hblank = 1'b1;
        vblank = 1'b1;
        repeat (8) begin
            cyc(1);
            pulses += int'(o_frame);
        end
        vblank = 1'b0;
        repeat (4) begin
            cyc(1);
            pulses += int'(o_frame);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; hsync = 1'b1; vsync = 1'b1; hblank = 1'b1; vblank = 1'b0;
        x = 12'd0; y = 12'd0; sel = 2'd0;
        cyc(3);
        checks++;
        if ({o_hsync, o_vsync, rgb, o_frame} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 110000", {o_hsync, o_vsync, rgb, o_frame});
        end
        checks++;
        if (dut.cx_c !== 12'd320 || dut.cy_c !== 12'd240) begin
            errors++;
            $display("FAIL reset_centre: got (%0d,%0d) required (320,240)", dut.cx_c, dut.cy_c);
        end
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_static();
        int p;
        sel = 2'd0;
        do_tick(p);
        checks++;
        if (p !== 1) begin
            errors++;
            $display("FAIL static_frame_pulse: got %0d required 1", p);
        end
        checks++;
        if (dut.cx_c !== 12'd320 || dut.cy_c !== 12'd240) begin
            errors++;
            $display("FAIL static_centre: got (%0d,%0d) required (320,240)", dut.cx_c, dut.cy_c);
        end
    endtask

    task automatic test_pixels();
        int         px [11] = '{320, 420, 419, 320, 320,   0, 639, 320,   5, 320, 320};
        int         py [11] = '{240, 240, 240, 340, 339,   5, 240,   0, 479, 240, 240};
        logic       hb [11] = '{  0,   0,   0,   0,   0,   0,   0,   0,   0,   1,   0};
        logic       vb [11] = '{  0,   0,   0,   0,   0,   0,   0,   0,   0,   0,   1};
        logic [2:0] ex [11] = '{  7,   0,   7,   0,   7,   4,   4,   4,   4,   0,   0};
        for (int i = 0; i < 11; i++) begin
            x = 12'(px[i]); y = 12'(py[i]); hblank = hb[i]; vblank = vb[i];
            cyc(3);
            checks++;
            if (rgb !== ex[i]) begin
                errors++;
                $display("FAIL pixel_%0d_%0d: got %b required %b", px[i], py[i], rgb, ex[i]);
            end
        end
        cyc(4);
        vblank = 1'b0; hblank = 1'b1;
        cyc(2);
    endtask

    task automatic test_latency();
        hblank = 1'b1; vblank = 1'b0; hsync = 1'b1; vsync = 1'b1;
        cyc(4);
        x = 12'd320; y = 12'd240; hblank = 1'b0; hsync = 1'b0; vsync = 1'b0;
        cyc(1);
        hblank = 1'b1; hsync = 1'b1; vsync = 1'b1;
        checks++;
        if ({o_hsync, o_vsync, rgb} !== 5'b11000) begin
            errors++;
            $display("FAIL latency_edge1: got %b required 11000", {o_hsync, o_vsync, rgb});
        end
        cyc(1);
        checks++;
        if ({o_hsync, o_vsync, rgb} !== 5'b11000) begin
            errors++;
            $display("FAIL latency_edge2: got %b required 11000", {o_hsync, o_vsync, rgb});
        end
        cyc(1);
        checks++;
        if ({o_hsync, o_vsync, rgb} !== 5'b00111) begin
            errors++;
            $display("FAIL latency_edge3: got %b required 00111", {o_hsync, o_vsync, rgb});
        end
        cyc(1);
        checks++;
        if ({o_hsync, o_vsync, rgb} !== 5'b11000) begin
            errors++;
            $display("FAIL latency_edge4: got %b required 11000", {o_hsync, o_vsync, rgb});
        end
    endtask

    task automatic test_motion();
        int p;
        int total = 0;
        int ex_x [5] = '{324, 460, 536, 539, 535};
        int ex_y [5] = '{244, 379, 303, 299, 295};
        int at_t [5] = '{  1,  35,  54,  55,  56};
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        sel = 2'd3;
        for (int t = 1; t <= 56; t++) begin
            do_tick(p);
            total += p;
            for (int k = 0; k < 5; k++) begin
                if (at_t[k] == t) begin
                    checks++;
                    if (dut.cx_c !== 12'(ex_x[k]) || dut.cy_c !== 12'(ex_y[k])) begin
                        errors++;
                        $display("FAIL motion_tick%0d: got (%0d,%0d) required (%0d,%0d)",
                                 t, dut.cx_c, dut.cy_c, ex_x[k], ex_y[k]);
                    end
                end
            end
            if (t == 1) begin
                checks++;
                if (dut_c.cx_c !== 12'd539 || dut_c.cy_c !== 12'd379) begin
                    errors++;
                    $display("FAIL corner_tick1: got (%0d,%0d) required (539,379)", dut_c.cx_c, dut_c.cy_c);
                end
            end
            if (t == 2) begin
                checks++;
                if (dut_c.cx_c !== 12'd535 || dut_c.cy_c !== 12'd375) begin
                    errors++;
                    $display("FAIL corner_tick2: got (%0d,%0d) required (535,375)", dut_c.cx_c, dut_c.cy_c);
                end
            end
        end
        checks++;
        if (total !== 56) begin
            errors++;
            $display("FAIL motion_frame_pulses: got %0d required 56", total);
        end
    endtask

    task automatic test_midframe();
        int bad = 0;
        int p;
        hblank = 1'b0; vblank = 1'b0;
        x = 12'd535; y = 12'd295;
        cyc(3);
        checks++;
        if (rgb !== 3'b111) begin
            errors++;
            $display("FAIL midframe_centre_before: got %b required 111", rgb);
        end
        for (int i = 0; i < 20; i++) begin
            sel = 2'(i);
            cyc(1);
            if (dut.cx_c !== 12'd535 || dut.cy_c !== 12'd295 || rgb !== 3'b111) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL midframe_stable: got %0d changed cycles required 0", bad);
        end
        x = 12'd635;
        cyc(3);
        checks++;
        if (rgb !== 3'b000) begin
            errors++;
            $display("FAIL midframe_edge_pixel: got %b required 000", rgb);
        end
        sel = 2'd1;
        do_tick(p);
        checks++;
        if (dut.cx_c !== 12'd534 || dut.cy_c !== 12'd294) begin
            errors++;
            $display("FAIL midframe_next_frame: got (%0d,%0d) required (534,294)", dut.cx_c, dut.cy_c);
        end
    endtask

    task automatic test_reset_midline();
        hblank = 1'b0; vblank = 1'b0; hsync = 1'b0; vsync = 1'b0;
        x = 12'd534; y = 12'd294;
        cyc(4);
        checks++;
        if ({o_hsync, o_vsync, rgb} !== 5'b00111) begin
            errors++;
            $display("FAIL midline_before: got %b required 00111", {o_hsync, o_vsync, rgb});
        end
        rst = 1'b1;
        x = 12'd320; y = 12'd240;
        for (int i = 0; i < 2; i++) begin
            cyc(1);
            checks++;
            if ({o_hsync, o_vsync, rgb, o_frame} !== 6'b110000) begin
                errors++;
                $display("FAIL midline_in_reset_%0d: got %b required 110000", i, {o_hsync, o_vsync, rgb, o_frame});
            end
        end
        checks++;
        if (dut.cx_c !== 12'd320 || dut.cy_c !== 12'd240) begin
            errors++;
            $display("FAIL midline_centre: got (%0d,%0d) required (320,240)", dut.cx_c, dut.cy_c);
        end
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cyc(1);
            checks++;
            if (i < 3 && {o_hsync, o_vsync, rgb} !== 5'b11000) begin
                errors++;
                $display("FAIL midline_release_%0d: got %b required 11000", i, {o_hsync, o_vsync, rgb});
            end else if (i == 3 && {o_hsync, o_vsync, rgb} !== 5'b00111) begin
                errors++;
                $display("FAIL midline_release_3: got %b required 00111", {o_hsync, o_vsync, rgb});
            end
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_pixels();
        test_latency();
        test_motion();
        test_midframe();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
